// File: rtl/rx_frame_defs.sv
// Shared framing definitions: symbol codes, parser states and error causes.
// Imported by the parser, the classifier and any stream generator.
package rx_frame_defs;

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_STP = 8'hFB;
    localparam logic [7:0] SYM_SDP = 8'h5C;
    localparam logic [7:0] SYM_END = 8'hFD;
    localparam logic [7:0] SYM_IDL = 8'h7C;

    localparam int LOCK_COM_COUNT = 4;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKED   = 2'd1,
        ST_IN_TLP   = 2'd2,
        ST_IN_DLLP  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        K_DATA = 3'd0,
        K_COM  = 3'd1,
        K_SKP  = 3'd2,
        K_STP  = 3'd3,
        K_SDP  = 3'd4,
        K_END  = 3'd5,
        K_IDL  = 3'd6
    } sym_kind_t;

    localparam logic [2:0] ERR_END_NO_START = 3'd1;
    localparam logic [2:0] ERR_STRAY_DATA   = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW     = 3'd3;
    localparam logic [2:0] ERR_EMPTY        = 3'd4;
    localparam logic [2:0] ERR_NESTED       = 3'd5;
    localparam logic [2:0] ERR_TRUNCATED    = 3'd6;
    localparam logic [2:0] ERR_LEN_MISMATCH = 3'd7;

endpackage

// File: rtl/rx_sym_classify.sv
// Combinational symbol decoder: exactly one of the outputs is high for any byte.
module rx_sym_classify
    import rx_frame_defs::*;
(
    input  logic [7:0] data_in,
    output logic       is_com,
    output logic       is_skp,
    output logic       is_stp,
    output logic       is_sdp,
    output logic       is_end,
    output logic       is_idl,
    output logic       is_data
);

    assign is_com  = (data_in == SYM_COM);
    assign is_skp  = (data_in == SYM_SKP);
    assign is_stp  = (data_in == SYM_STP);
    assign is_sdp  = (data_in == SYM_SDP);
    assign is_end  = (data_in == SYM_END);
    assign is_idl  = (data_in == SYM_IDL);
    assign is_data = ~(is_com | is_skp | is_stp | is_sdp | is_end | is_idl);

endmodule

// File: rtl/rx_frame_parser.sv
// Receive framing parser: acquires COM lock, then extracts TLP/DLLP payloads
// with one registered cycle of latency and reports framing errors as pulses.
//
// Input handshake: valid_in qualifies data_in for one cycle; there is no
// backpressure, every valid byte is consumed. valid_out, pkt_done and err are
// single-cycle pulses; data_out/pkt_type/pkt_len/err_code are meaningful only
// alongside their qualifying pulse.
module rx_frame_parser
    import rx_frame_defs::*;
#(
    parameter int MAX_TLP  = 16,
    parameter int DLLP_LEN = 2
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       locked,
    output logic       valid_out,
    output logic [7:0] data_out,
    output logic       pkt_done,
    output logic       pkt_type,
    output logic [4:0] pkt_len,
    output logic       err,
    output logic [2:0] err_code,
    output logic [7:0] pkt_cnt,
    output logic [1:0] state_dbg
);

    localparam logic [4:0] TLP_MAX_LEN  = 5'(MAX_TLP);
    localparam logic [4:0] DLLP_REQ_LEN = 5'(DLLP_LEN);
    localparam logic [1:0] COM_LAST     = 2'(LOCK_COM_COUNT - 1);

    logic is_com, is_skp, is_stp, is_sdp, is_end, is_idl, is_data;
    sym_kind_t kind;

    rx_sym_classify u_classify (
        .data_in (data_in),
        .is_com  (is_com),
        .is_skp  (is_skp),
        .is_stp  (is_stp),
        .is_sdp  (is_sdp),
        .is_end  (is_end),
        .is_idl  (is_idl),
        .is_data (is_data)
    );

    always_comb begin
        kind = K_DATA;
        unique case (1'b1)
            is_com:  kind = K_COM;
            is_skp:  kind = K_SKP;
            is_stp:  kind = K_STP;
            is_sdp:  kind = K_SDP;
            is_end:  kind = K_END;
            is_idl:  kind = K_IDL;
            is_data: kind = K_DATA;
            default: kind = K_DATA;
        endcase
    end

    state_t     state_q, state_d;
    logic [1:0] com_cnt_q, com_cnt_d;
    logic [4:0] len_q, len_d;
    logic       locked_q, locked_d;
    logic       valid_out_q, valid_out_d;
    logic [7:0] data_out_q, data_out_d;
    logic       pkt_done_q, pkt_done_d;
    logic       pkt_type_q, pkt_type_d;
    logic [4:0] pkt_len_q, pkt_len_d;
    logic       err_q, err_d;
    logic [2:0] err_code_q, err_code_d;
    logic [7:0] pkt_cnt_q, pkt_cnt_d;

    logic       in_tlp;
    logic [4:0] len_limit;

    assign in_tlp    = (state_q == ST_IN_TLP);
    assign len_limit = in_tlp ? TLP_MAX_LEN : DLLP_REQ_LEN;

    always_comb begin
        state_d     = state_q;
        com_cnt_d   = com_cnt_q;
        len_d       = len_q;
        locked_d    = locked_q;
        valid_out_d = 1'b0;
        data_out_d  = data_out_q;
        pkt_done_d  = 1'b0;
        pkt_type_d  = pkt_type_q;
        pkt_len_d   = pkt_len_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        pkt_cnt_d   = pkt_cnt_q;

        if (valid_in) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (kind == K_COM) begin
                        if (com_cnt_q == COM_LAST) begin
                            state_d   = ST_LOCKED;
                            locked_d  = 1'b1;
                            com_cnt_d = 2'd0;
                        end else begin
                            com_cnt_d = com_cnt_q + 2'd1;
                        end
                    end else begin
                        com_cnt_d = 2'd0;
                    end
                end

                ST_LOCKED: begin
                    case (kind)
                        K_STP: begin
                            state_d = ST_IN_TLP;
                            len_d   = 5'd0;
                        end
                        K_SDP: begin
                            state_d = ST_IN_DLLP;
                            len_d   = 5'd0;
                        end
                        K_END: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_END_NO_START;
                        end
                        K_DATA: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_STRAY_DATA;
                        end
                        default: ;
                    endcase
                end

                ST_IN_TLP, ST_IN_DLLP: begin
                    case (kind)
                        K_DATA: begin
                            // A byte beyond the length limit is dropped, not forwarded.
                            if (len_q == len_limit) begin
                                err_d      = 1'b1;
                                err_code_d = in_tlp ? ERR_OVERFLOW : ERR_LEN_MISMATCH;
                                state_d    = ST_LOCKED;
                            end else begin
                                valid_out_d = 1'b1;
                                data_out_d  = data_in;
                                len_d       = len_q + 5'd1;
                            end
                        end
                        K_END: begin
                            state_d = ST_LOCKED;
                            if (in_tlp && len_q == 5'd0) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_EMPTY;
                            end else if (!in_tlp && len_q != DLLP_REQ_LEN) begin
                                err_d      = 1'b1;
                                err_code_d = ERR_LEN_MISMATCH;
                            end else begin
                                pkt_done_d = 1'b1;
                                pkt_type_d = ~in_tlp;
                                pkt_len_d  = len_q;
                                pkt_cnt_d  = pkt_cnt_q + 8'd1;
                            end
                        end
                        K_STP, K_SDP: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_NESTED;
                            state_d    = (kind == K_STP) ? ST_IN_TLP : ST_IN_DLLP;
                            len_d      = 5'd0;
                        end
                        K_COM, K_IDL: begin
                            err_d      = 1'b1;
                            err_code_d = ERR_TRUNCATED;
                            state_d    = ST_LOCKED;
                        end
                        default: ;
                    endcase
                end

                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_UNLOCKED;
            com_cnt_q   <= 2'd0;
            len_q       <= 5'd0;
            locked_q    <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= 8'd0;
            pkt_done_q  <= 1'b0;
            pkt_type_q  <= 1'b0;
            pkt_len_q   <= 5'd0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
            pkt_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            com_cnt_q   <= com_cnt_d;
            len_q       <= len_d;
            locked_q    <= locked_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            pkt_done_q  <= pkt_done_d;
            pkt_type_q  <= pkt_type_d;
            pkt_len_q   <= pkt_len_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign pkt_done  = pkt_done_q;
    assign pkt_type  = pkt_type_q;
    assign pkt_len   = pkt_len_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: doc/rx_frame_parser.md
RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 Parameter MAX_TLP, default 16: maximum TLP payload bytes accepted.
REQ-002 Parameter DLLP_LEN, default 2: exact DLLP payload byte count required.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_L  in  1  asynchronous active-low reset.
REQ-005 valid_in  in  1  data_in carries a byte this cycle.
REQ-006 data_in  in  8  received symbol stream.
REQ-007 locked  out  1  symbol alignment achieved.
REQ-008 valid_out  out  1  data_out holds one payload byte.
REQ-009 data_out  out  8  payload byte.
REQ-010 pkt_done  out  1  one-cycle pulse: packet closed cleanly.
REQ-011 pkt_type  out  1  0=TLP (STP), 1=DLLP (SDP); valid with pkt_done.
REQ-012 pkt_len  out  5  payload byte count; valid with pkt_done.
REQ-013 err  out  1  one-cycle pulse: framing error.
REQ-014 err_code  out  3  error cause; valid with err.
REQ-015 pkt_cnt  out  8  good packets received, wraps 255->0.

Function
REQ-016 Control symbols SHALL be COM=8'hBC, SKP=8'h1C, STP=8'hFB, SDP=8'h5C, END=8'hFD, IDL=8'h7C; any other byte SHALL be a data byte.
REQ-017 All outputs SHALL be registered; one-cycle latency from accepted input byte to output.
REQ-018 Cycles with valid_in=0 SHALL change no state; pulse outputs SHALL be 0.
REQ-019 States: UNLOCKED, LOCKED, IN_TLP, IN_DLLP.
REQ-020 UNLOCKED: count consecutive COM; non-COM clears count; 4th consecutive COM -> LOCKED, locked=1 next cycle.
REQ-021 LOCKED: COM/SKP/IDL ignored; STP -> IN_TLP; SDP -> IN_DLLP; both clear length counter.
REQ-022 LOCKED: END -> err_code 1 (END without start); data byte -> err_code 2 (stray data); state stays LOCKED.
REQ-023 IN_TLP/IN_DLLP: data byte -> valid_out=1, data_out=byte, length+1.
REQ-024 SKP inside a packet SHALL be dropped silently and SHALL not end the packet.
REQ-025 END in IN_TLP with length 1..MAX_TLP -> pkt_done, pkt_type=0, pkt_len=length, pkt_cnt+1, go LOCKED.
REQ-026 END in IN_TLP with length 0 -> err_code 4 (empty), go LOCKED.
REQ-027 Data byte when TLP length==MAX_TLP -> err_code 3 (overflow), byte not output, go LOCKED.
REQ-028 IN_DLLP: END with length==DLLP_LEN -> pkt_done, pkt_type=1; otherwise err_code 7 (length mismatch); go LOCKED.
REQ-029 IN_DLLP: data byte when length==DLLP_LEN -> err_code 7, byte not output, go LOCKED.
REQ-030 STP/SDP inside a packet -> err_code 5 (nested start); current packet aborted; new packet of indicated type starts, length 0.
REQ-031 COM/IDL inside a packet -> err_code 6 (truncated), go LOCKED.
REQ-032 pkt_done and err SHALL never assert in the same cycle.
REQ-033 After lock, the block SHALL remain locked until reset.

Reset
REQ-034 reset_L=0 SHALL immediately force UNLOCKED, COM count 0, length 0, and all outputs 0 (locked, valid_out, data_out, pkt_done, pkt_type, pkt_len, err, err_code, pkt_cnt).
REQ-035 Reset mid-packet SHALL discard the packet without pkt_done or err; relock requires 4 new COMs.

Structure
REQ-036 Symbol constants, state encodings and err_code values SHALL live in shared include rx_frame_defs, common with the stream generators.
REQ-037 Symbol classification SHALL be a combinational sub-module rx_sym_classify (data_in -> is_com, is_skp, is_stp, is_sdp, is_end, is_idl, is_data).

Verification
REQ-038 BC x4 -> locked=1 in cycle after 4th BC; BC,BC,7C,BC x3 -> locked stays 0.
REQ-039 Locked; FB,01,02,FD -> valid_out on 01,02; pkt_done, pkt_type=0, pkt_len=2, pkt_cnt=1.
REQ-040 Locked; BC x4, 1C x12, FB,03..0C,FD -> SKPs ignored; 10 payload bytes; pkt_done, pkt_len=10.
REQ-041 Locked; 5C,0D,0E,FD then 7C x8 -> pkt_done, pkt_type=1, pkt_len=2; no err during IDL.
REQ-042 Locked; FB + 17 data bytes -> 16 bytes output, err_code=3 on 17th; FD -> err_code=1; 5C,0D,FD -> err_code=7.
REQ-043 reset_L low mid-TLP (FB,01, reset) -> all outputs 0 asynchronously; no pkt_done; locked=0 until 4 BC.
